// File: rtl/seq_alu_responder.sv
// seq_alu_responder: multi-cycle ALU that evaluates one SLICE_W-bit slice per
// cycle, with valid/ready request and response channels.
// Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS B.
// Optional feature macro: SEQ_ALU_FLAGS_EN adds the Carry and Overflow outputs.
module seq_alu_responder #(
    parameter int WIDTH   = 64,
    parameter int SLICE_W = 16
) (
    input  logic             Clk,
    input  logic             Resetb,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [3:0]       ALUCtrl,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero,
    output logic             Illegal
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic             Carry,
    output logic             Overflow
`endif
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    // Reject slice widths that do not tile the operand exactly.
    generate
        if ((WIDTH % SLICE_W) != 0) begin : g_bad_slice
            $error("SLICE_W must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               resp_valid_q;
    logic [WIDTH-1:0]   busw_q;
    logic               zero_q;
    logic               illegal_q;

    // Operands shift right by one slice per BUSY cycle so slice i is always
    // found in the low bits; the accumulator fills from the top downwards.
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;

    logic [SLICE_W-1:0] a_s;
    logic [SLICE_W-1:0] b_s;
    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W:0]   sum_s;
    logic [SLICE_W-1:0] res_s;
    logic               cout_s;
    logic               legal_s;
    logic               req_fire;

`ifdef SEQ_ALU_FLAGS_EN
    logic               carry_flag_q;
    logic               ovf_flag_q;
    logic               ovf_s;
    logic               arith_s;
`endif

    assign ReqReady  = (state_q == ST_IDLE);
    assign req_fire  = ReqValid && ReqReady;
    assign RespValid = resp_valid_q;
    assign BusW      = busw_q;
    assign Zero      = zero_q;
    assign Illegal   = illegal_q;

`ifdef SEQ_ALU_FLAGS_EN
    assign Carry    = carry_flag_q;
    assign Overflow = ovf_flag_q;
`endif

    // Evaluate the current slice and form the next accumulator value.
    always_comb begin
        a_s     = a_q[SLICE_W-1:0];
        b_s     = b_q[SLICE_W-1:0];
        b_eff   = (op_q == OP_SUB) ? ~b_s : b_s;
        sum_s   = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry_q};
        res_s   = '0;
        cout_s  = 1'b0;
        legal_s = 1'b1;
        case (op_q)
            OP_AND:  res_s = a_s & b_s;
            OP_OR:   res_s = a_s | b_s;
            OP_ADD,
            OP_SUB: begin
                res_s  = sum_s[SLICE_W-1:0];
                cout_s = sum_s[SLICE_W];
            end
            OP_PASS: res_s = b_s;
            default: legal_s = 1'b0;
        endcase
        acc_d = (acc_q >> SLICE_W) | (WIDTH'(res_s) << (WIDTH - SLICE_W));
    end

`ifdef SEQ_ALU_FLAGS_EN
    // Signed overflow is judged on the most significant slice only; it is
    // captured when that slice is the last one evaluated.
    always_comb begin
        arith_s = (op_q == OP_ADD) || (op_q == OP_SUB);
        ovf_s   = arith_s && (a_s[SLICE_W-1] == b_eff[SLICE_W-1]) &&
                  (res_s[SLICE_W-1] != a_s[SLICE_W-1]);
    end
`endif

    // Operand capture and slice-by-slice accumulation (no reset needed).
    always_ff @(posedge Clk) begin
        if (req_fire) begin
            a_q   <= BusA;
            b_q   <= BusB;
            op_q  <= ALUCtrl;
            acc_q <= '0;
        end else if (state_q == ST_BUSY) begin
            a_q   <= a_q >> SLICE_W;
            b_q   <= b_q >> SLICE_W;
            acc_q <= acc_d;
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge Clk) begin
        if (!Resetb) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            busw_q       <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            carry_flag_q <= 1'b0;
            ovf_flag_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        idx_q   <= '0;
                        carry_q <= (ALUCtrl == OP_SUB);
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    carry_q <= cout_s;
                    if (idx_q == LAST_IDX) begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= 1'b1;
                        busw_q       <= acc_d;
                        zero_q       <= (acc_d == '0);
                        illegal_q    <= !legal_s;
`ifdef SEQ_ALU_FLAGS_EN
                        carry_flag_q <= arith_s && cout_s;
                        ovf_flag_q   <= ovf_s;
`endif
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (RespReady) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_responder.sv
// Scoreboard bench for seq_alu_responder: directed cases, backpressure,
// mid-operation reset, illegal opcode, then randomized traffic.
module tb_seq_alu_responder;

    logic        Clk = 1'b0;
    logic        Resetb;
    logic        ReqValid;
    logic        ReqReady;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [3:0]  ALUCtrl;
    logic        RespValid;
    logic        RespReady;
    logic [63:0] BusW;
    logic        Zero;
    logic        Illegal;
`ifdef SEQ_ALU_FLAGS_EN
    logic        Carry;
    logic        Overflow;
`endif

    always #5 Clk = ~Clk;

    seq_alu_responder #(.WIDTH(64), .SLICE_W(16)) dut (
        .Clk(Clk), .Resetb(Resetb),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl),
        .RespValid(RespValid), .RespReady(RespReady),
        .BusW(BusW), .Zero(Zero), .Illegal(Illegal)
`ifdef SEQ_ALU_FLAGS_EN
        , .Carry(Carry), .Overflow(Overflow)
`endif
    );

    typedef struct {
        logic [63:0] w;
        logic        z;
        logic        il;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   rnd_rr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic on whole operands.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [64:0] wide;
        e.w = '0; e.il = 1'b0; e.c = 1'b0; e.v = 1'b0;
        case (op)
            4'b0000: e.w = a & b;
            4'b0001: e.w = a | b;
            4'b0010: begin
                wide = {1'b0, a} + {1'b0, b};
                e.w  = wide[63:0];
                e.c  = wide[64];
                e.v  = (a[63] == b[63]) && (e.w[63] != a[63]);
            end
            4'b0110: begin
                e.w = a - b;
                e.c = (a >= b);
                e.v = (a[63] != b[63]) && (e.w[63] != a[63]);
            end
            4'b0111: e.w = b;
            default: e.il = 1'b1;
        endcase
        e.z = (e.w == 64'd0);
        return e;
    endfunction

    // Monitor: every accepted response is matched against the queue head.
    always @(negedge Clk) begin
        if (Resetb === 1'b1 && RespValid === 1'b1 && RespReady === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp BusW=0x%0h required=no response", BusW);
            end else begin
                mon_e = sb.pop_front();
                chk("BusW", BusW, mon_e.w);
                chk("Zero", 64'(Zero), 64'(mon_e.z));
                chk("Illegal", 64'(Illegal), 64'(mon_e.il));
`ifdef SEQ_ALU_FLAGS_EN
                chk("Carry", 64'(Carry), 64'(mon_e.c));
                chk("Overflow", 64'(Overflow), 64'(mon_e.v));
`endif
            end
        end
    end

    // Random response backpressure during the random phase.
    always @(posedge Clk) begin
        if (rnd_rr) begin
            #1;
            RespReady = ($urandom_range(0, 3) != 0);
        end
    end

    // Issue one request; called just after a rising edge, returns just after the handshake edge.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input bit push);
        int n;
        n = 0;
        ReqValid = 1'b1;
        ALUCtrl  = op;
        BusA     = a;
        BusB     = b;
        @(negedge Clk);
        while (!ReqReady && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!ReqReady) begin
            checks++;
            errors++;
            $display("FAIL req_timeout ReqReady=%0b required=1", ReqReady);
        end else if (push) begin
            sb.push_back(model(op, a, b));
        end
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        BusA     = {$urandom, $urandom};
        BusB     = {$urandom, $urandom};
        ALUCtrl  = 4'($urandom);
    endtask

    // RespValid must rise exactly after the 4th edge following the handshake.
    task automatic lat_check();
        for (int i = 1; i <= 4; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("latency_edge%0d", i), 64'(RespValid), (i == 4) ? 64'd1 : 64'd0);
        end
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0] ops [6];
        int wait_n;
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
        ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1111;

        Resetb = 1'b0; ReqValid = 1'b0; RespReady = 1'b1;
        BusA = '0; BusB = '0; ALUCtrl = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ReqReady", 64'(ReqReady), 64'd1);
        chk("rst_RespValid", 64'(RespValid), 64'd0);
        chk("rst_BusW", BusW, 64'd0);
        chk("rst_Zero", 64'(Zero), 64'd0);
        chk("rst_Illegal", 64'(Illegal), 64'd0);
        Resetb = 1'b1;
        @(posedge Clk);
        #1;

        // Directed operations
        issue(4'b0010, 64'hACEB, 64'hABDDE000, 1'b1);          lat_check();
        issue(4'b0010, 64'hFFFF, 64'h1, 1'b1);                 lat_check();
        issue(4'b0110, 64'h0, 64'h12ED, 1'b1);                 lat_check();
        issue(4'b0000, 64'h98760000, 64'h0, 1'b1);             lat_check();
        issue(4'b0111, {$urandom, $urandom}, 64'h87654321, 1'b1); lat_check();

        // Backpressure: response held, second request refused
        RespReady = 1'b0;
        issue(4'b0001, 64'h10101010, 64'h01010101, 1'b1);
        repeat (4) @(posedge Clk);
        #1;
        ReqValid = 1'b1;
        ALUCtrl  = 4'b0010;
        BusA     = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_RespValid", 64'(RespValid), 64'd1);
            chk("bp_BusW", BusW, 64'h11111111);
            chk("bp_ReqReady", 64'(ReqReady), 64'd0);
            @(posedge Clk);
            #1;
        end
        ReqValid  = 1'b0;
        RespReady = 1'b1;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("bp_release_ReqReady", 64'(ReqReady), 64'd1);
        chk("bp_release_RespValid", 64'(RespValid), 64'd0);
        @(posedge Clk);
        #1;

        // Reset mid-operation after slice 1
        issue(4'b0010, 64'h1234, 64'h5678, 1'b0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Resetb = 1'b0;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        chk("midrst_RespValid", 64'(RespValid), 64'd0);
        chk("midrst_BusW", BusW, 64'd0);
        chk("midrst_ReqReady", 64'(ReqReady), 64'd1);
        Resetb = 1'b1;
        repeat (6) begin
            @(posedge Clk);
            @(negedge Clk);
            chk("midrst_no_resp", 64'(RespValid), 64'd0);
        end
        @(posedge Clk);
        #1;
        issue(4'b0010, 64'hDEAD_BEEF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b1); lat_check();

        // Illegal opcode, then a legal one clears Illegal
        issue(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1); lat_check();
        issue(4'b0001, 64'h0F0F, 64'hF000, 1'b1);              lat_check();

        // Randomized traffic with random backpressure
        rnd_rr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(ops[$urandom_range(0, 5)], rnd_operand(), rnd_operand(), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            #1;
        end
        rnd_rr = 1'b0;
        @(posedge Clk);
        #2;
        RespReady = 1'b1;
        wait_n = 0;
        while (sb.size() != 0 && wait_n < 100) begin
            @(posedge Clk);
            wait_n++;
        end
        @(negedge Clk);
        chk("drain_queue_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu_responder.md
Name: seq_alu_responder

Overview:
- Multi-cycle 64-bit ALU with valid/ready request and response channels.
- Datapath sequencing layer for the single-cycle ALU: same opcode encoding, same BusA/BusB/BusW/Zero semantics.
- Evaluates one SLICE_W-bit slice per cycle, carry/borrow registered between slices.
- Sits between the datapath controller (initiator) and the register writeback path.

Parameters:
- WIDTH, 64, operand/result width.
- SLICE_W, 16, bits evaluated per cycle. Must divide WIDTH; legal values 8, 16, 32, 64.

Ports:
- Clk  input  1  rising-edge clock
- Resetb  input  1  synchronous active-low reset, sampled on Clk rising edge
- ReqValid  input  1  request present
- ReqReady  output  1  responder can accept a request
- BusA  input  WIDTH  operand A, sampled at request handshake
- BusB  input  WIDTH  operand B, sampled at request handshake
- ALUCtrl  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS B
- RespValid  output  1  result available
- RespReady  input  1  consumer accepts result
- BusW  output  WIDTH  result
- Zero  output  1  BusW == 0
- Illegal  output  1  opcode not in the supported set

Behaviour:
- Reset (Resetb=0 at a Clk edge): state=IDLE, BusW=0, Zero=0, Illegal=0, RespValid=0, slice index=0, carry=0. Reset mid-operation abandons the operation; no response is produced.
- ReqReady = (state==IDLE). It is combinational from state only and does not depend on ReqValid.
- IDLE:
  - On ReqValid&&ReqReady: latch BusA, BusB, ALUCtrl.
  - Set carry-in = 1 for SUB, else 0. Index = 0. Go to BUSY.
- BUSY, one slice per cycle, index i = 0..N-1, N = WIDTH/SLICE_W:
  - AND/OR/PASS B: bitwise on slice i.
  - ADD: A_i + B_i + c.
  - SUB: A_i + ~B_i + c.
  - Slice carry-out is registered into c. Result slice i is written to the internal accumulator.
  - After slice N-1 go to DONE.
- DONE:
  - BusW = accumulator. Zero = (accumulator==0). Illegal = (latched opcode unsupported).
  - RespValid=1, held stable with BusW/Zero/Illegal until RespReady=1 at an edge, then go to IDLE with RespValid=0.
- Latency: request handshake at edge k; RespValid=1 after edge k+N (N=4 by default). With RespReady held high, throughput is one result per N+2 cycles.
- BusW/Zero/Illegal outputs:
  - Update only on entry to DONE.
  - Hold their last values in IDLE/BUSY.
  - Valid only while RespValid=1.
- Unsupported opcode: full N-cycle sequence runs; BusW=0, Zero=1, Illegal=1.
- Arithmetic: modulo 2^WIDTH; the final carry is discarded.
- Input changes on BusA/BusB/ALUCtrl during BUSY/DONE have no effect.
- ReqValid during BUSY/DONE is ignored. The initiator holds it until ReqReady.
- RespReady while RespValid=0 has no effect.

Optional Feature:
- SEQ_ALU_FLAGS_EN defined:
  - Adds outputs Carry (1) and Overflow (1), updated on entry to DONE with the other result outputs.
  - ADD/SUB: Carry = final carry out of bit WIDTH-1 (SUB: 1 = no borrow); Overflow = signed overflow of the WIDTH-bit result.
  - Other opcodes: both 0.
  - Reset value: both 0.
- SEQ_ALU_FLAGS_EN undefined: the ports do not exist and no flag logic is built. All other behaviour is identical.

Test Plan:
- Directed ops, each with RespReady=1 and RespValid checked exactly 4 cycles after the request handshake:
  - ADD 0xACEB + 0xABDDE000 -> BusW=0xABDE8CEB, Zero=0.
  - ADD 0xFFFF + 0x1 -> BusW=0x10000 (carry crosses a slice boundary).
- SUB 0x0 - 0x12ED -> BusW=0xFFFFFFFFFFFFED13, Zero=0 (borrow propagates through all 4 slices). With SEQ_ALU_FLAGS_EN: Carry=0, Overflow=0.
- AND 0x98760000 & 0x0 -> BusW=0, Zero=1. PASS B with B=0x87654321 -> BusW=0x87654321, Zero=0.
- Backpressure:
  - OR 0x10101010 | 0x01010101 with RespReady=0 for 5 cycles -> RespValid stays 1, BusW stays 0x11111111 and stable, ReqReady stays 0.
  - A second ReqValid in that window is not accepted.
  - Raising RespReady -> IDLE next edge, ReqReady=1.
- Reset mid-operation: deassert Resetb during BUSY (after slice 1) -> next edge state IDLE, RespValid=0, BusW=0, ReqReady=1. A following ADD completes correctly.
- ALUCtrl=4'b1111 -> after 4 cycles RespValid=1, BusW=0, Zero=1, Illegal=1. The next legal op clears Illegal.
